// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : stopwatch_ctrl_if
// Description : Button inputs and display/status outputs of the stopwatch
//               sequencing controller. The master side presses buttons and
//               watches the display; the slave side is the controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [11:0] bcd;
    logic        running;
    logic        lap_active;
    logic        done;
    logic        ovf;

    modport master (
        output start_stop, lap, clear,
        input  bcd, running, lap_active, done, ovf
    );

    modport slave (
        input  start_stop, lap, clear,
        output bcd, running, lap_active, done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : stopwatch_ctrl
// Description : Run/pause/lap/done sequencer for a 3-digit BCD seconds count.
//               Gates a TICK_DIV-cycle prescaler, cascades ones/tens/hundreds
//               and drives a display register that freezes while in LAP.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int WRAP     = 0
) (
    input  wire               clk,
    input  wire               sclr,
    stopwatch_ctrl_if.slave   bus
);

    localparam int                c_PW        = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0]   c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0]   c_PRESC_ONE = c_PW'(1);
    localparam logic              c_WRAP_EN   = (WRAP != 0);
    localparam logic [11:0]       c_CNT_MAX   = 12'h999;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_LAP   = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [2:0]      r_in_d;          // {clear, lap, start_stop} from last cycle
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic [11:0]     r_cnt;
    logic [11:0]     w_cnt_nxt;
    logic [11:0]     w_cnt_inc;
    logic [11:0]     r_bcd;
    logic [11:0]     w_bcd_nxt;
    logic            r_running, w_running_nxt;
    logic            r_lap_active, w_lap_active_nxt;
    logic            r_done, w_done_nxt;
    logic            r_ovf, w_ovf_nxt;

    logic w_ev_ss;
    logic w_ev_lap;
    logic w_ev_clr;
    logic w_counting;
    logic w_tick;
    logic w_at_max;
    logic w_stop_at_max;

    assign w_ev_ss       = bus.start_stop & ~r_in_d[0];
    assign w_ev_lap      = bus.lap        & ~r_in_d[1];
    assign w_ev_clr      = bus.clear      & ~r_in_d[2];
    assign w_counting    = (r_state == c_ST_RUN) || (r_state == c_ST_LAP);
    assign w_tick        = w_counting && (r_presc == c_PRESC_MAX);
    assign w_at_max      = (r_cnt == c_CNT_MAX);
    assign w_stop_at_max = w_tick && w_at_max && !c_WRAP_EN;

    // Cascaded BCD increment; the 999 case is resolved by the caller.
    always_comb begin
        w_cnt_inc = r_cnt;
        if (r_cnt[3:0] == 4'd9) begin
            w_cnt_inc[3:0] = 4'd0;
            if (r_cnt[7:4] == 4'd9) begin
                w_cnt_inc[7:4]  = 4'd0;
                w_cnt_inc[11:8] = (r_cnt[11:8] == 4'd9) ? 4'd0 : r_cnt[11:8] + 4'd1;
            end else begin
                w_cnt_inc[7:4] = r_cnt[7:4] + 4'd1;
            end
        end else begin
            w_cnt_inc[3:0] = r_cnt[3:0] + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (sclr) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state: clear outranks start_stop, which outranks lap; an event the
    // current state ignores does not mask a lower-priority one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ev_ss) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_ev_ss)            w_state_nxt = c_ST_PAUSE;
                else if (w_ev_lap)      w_state_nxt = c_ST_LAP;
                else if (w_stop_at_max) w_state_nxt = c_ST_DONE;
            end
            c_ST_LAP: begin
                if (w_ev_ss)            w_state_nxt = c_ST_PAUSE;
                else if (w_ev_lap)      w_state_nxt = c_ST_RUN;
                else if (w_stop_at_max) w_state_nxt = c_ST_DONE;
            end
            c_ST_PAUSE: begin
                if (w_ev_clr)     w_state_nxt = c_ST_IDLE;
                else if (w_ev_ss) w_state_nxt = c_ST_RUN;
            end
            c_ST_DONE: begin
                if (w_ev_clr) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next datapath and output values; outputs are registered from these so
    // they line up with the state they describe.
    always_comb begin
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        if (w_counting) begin
            w_presc_nxt = w_tick ? '0 : r_presc + c_PRESC_ONE;
            if (w_tick) begin
                if (w_at_max) w_cnt_nxt = c_WRAP_EN ? 12'h000 : r_cnt;
                else          w_cnt_nxt = w_cnt_inc;
            end
        end
        // IDLE keeps everything zeroed; leaving it starts a fresh second.
        if ((r_state == c_ST_IDLE) || (w_state_nxt == c_ST_IDLE)) begin
            w_presc_nxt = '0;
            w_cnt_nxt   = 12'h000;
        end
        // Display freezes only while staying in LAP; entering LAP captures.
        w_bcd_nxt        = ((r_state == c_ST_LAP) && (w_state_nxt == c_ST_LAP)) ? r_bcd : w_cnt_nxt;
        w_running_nxt    = (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_LAP);
        w_lap_active_nxt = (w_state_nxt == c_ST_LAP);
        w_done_nxt       = (w_state_nxt == c_ST_DONE);
        w_ovf_nxt        = w_tick && w_at_max && c_WRAP_EN;
    end

    // Datapath and output registers; edge detectors preset so a button held
    // through reset needs a release before it counts.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_in_d       <= 3'b111;
            r_presc      <= '0;
            r_cnt        <= 12'h000;
            r_bcd        <= 12'h000;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_in_d       <= {bus.clear, bus.lap, bus.start_stop};
            r_presc      <= w_presc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bcd        <= w_bcd_nxt;
            r_running    <= w_running_nxt;
            r_lap_active <= w_lap_active_nxt;
            r_done       <= w_done_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    assign bus.bcd        = r_bcd;
    assign bus.running    = r_running;
    assign bus.lap_active = r_lap_active;
    assign bus.done       = r_done;
    assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_stopwatch_ctrl
// Description : Directed bench for stopwatch_ctrl, TICK_DIV=4. One instance
//               stops at 999 (WRAP=0), the other wraps (WRAP=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int c_DIV = 4;

    logic clk;
    logic sclr;
    int   n_vec;
    int   n_err;

    stopwatch_ctrl_if b0 ();
    stopwatch_ctrl_if b1 ();

    stopwatch_ctrl #(.TICK_DIV(c_DIV), .WRAP(0)) u_dut0 (.clk(clk), .sclr(sclr), .bus(b0));
    stopwatch_ctrl #(.TICK_DIV(c_DIV), .WRAP(1)) u_dut1 (.clk(clk), .sclr(sclr), .bus(b1));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse; the event edge is the posedge inside the pulse.
    // which: 0 = start_stop, 1 = lap, 2 = clear.
    task automatic press(input int sel, input int which);
        if (sel == 0) begin
            if (which == 0) b0.start_stop = 1'b1;
            if (which == 1) b0.lap        = 1'b1;
            if (which == 2) b0.clear      = 1'b1;
        end else begin
            if (which == 0) b1.start_stop = 1'b1;
            if (which == 1) b1.lap        = 1'b1;
            if (which == 2) b1.clear      = 1'b1;
        end
        @(negedge clk);
        b0.start_stop = 1'b0; b0.lap = 1'b0; b0.clear = 1'b0;
        b1.start_stop = 1'b0; b1.lap = 1'b0; b1.clear = 1'b0;
    endtask

    // Reset plus one idle cycle so the preset edge detectors clear.
    task automatic do_reset();
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (b0.bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd got %h want 000", b0.bcd); end
        n_vec++; if ({b0.running, b0.lap_active, b0.done, b0.ovf} !== 4'b0000) begin n_err++;
            $display("FAIL reset_flags got %b want 0000", {b0.running, b0.lap_active, b0.done, b0.ovf}); end
        n_vec++; if ({b1.bcd, b1.running, b1.ovf} !== 14'd0) begin n_err++;
            $display("FAIL reset_dut1 got %h want 0", {b1.bcd, b1.running, b1.ovf}); end
    endtask

    task automatic test_start();
        do_reset();
        press(0, 0);
        n_vec++; if (b0.running !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", b0.running); end
        wait_n(3);
        n_vec++; if (b0.bcd !== 12'h000) begin n_err++; $display("FAIL start_k3 got %h want 000", b0.bcd); end
        wait_n(1);
        n_vec++; if (b0.bcd !== 12'h001) begin n_err++; $display("FAIL start_k4 got %h want 001", b0.bcd); end
        wait_n(36);
        n_vec++; if (b0.bcd !== 12'h010) begin n_err++; $display("FAIL start_k40 got %h want 010", b0.bcd); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        press(0, 0);
        wait_n(493);
        n_vec++; if (b0.bcd !== 12'h123) begin n_err++; $display("FAIL pause_pre got %h want 123", b0.bcd); end
        press(0, 0);  // event lands with prescaler at 2
        wait_n(20);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h123, 1'b0}) begin n_err++;
            $display("FAIL pause_hold got %h/%b want 123/0", b0.bcd, b0.running); end
        press(0, 0);
        wait_n(1);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h123, 1'b1}) begin n_err++;
            $display("FAIL resume_r1 got %h/%b want 123/1", b0.bcd, b0.running); end
        wait_n(1);
        n_vec++; if (b0.bcd !== 12'h124) begin n_err++; $display("FAIL resume_r2 got %h want 124", b0.bcd); end
        press(0, 0);
        press(0, 2);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h000, 1'b0}) begin n_err++;
            $display("FAIL clear_idle got %h/%b want 000/0", b0.bcd, b0.running); end
    endtask

    task automatic test_lap();
        do_reset();
        press(0, 0);
        wait_n(180);
        n_vec++; if (b0.bcd !== 12'h045) begin n_err++; $display("FAIL lap_pre got %h want 045", b0.bcd); end
        press(0, 1);
        n_vec++; if ({b0.lap_active, b0.running} !== 2'b11) begin n_err++;
            $display("FAIL lap_enter got %b want 11", {b0.lap_active, b0.running}); end
        wait_n(20);
        n_vec++; if (b0.bcd !== 12'h045) begin n_err++; $display("FAIL lap_frozen got %h want 045", b0.bcd); end
        press(0, 1);
        n_vec++; if ({b0.bcd, b0.lap_active, b0.running} !== {12'h050, 2'b01}) begin n_err++;
            $display("FAIL lap_exit got %h/%b want 050/01", b0.bcd, {b0.lap_active, b0.running}); end
    endtask

    task automatic test_done();
        do_reset();
        press(0, 0);
        wait_n(3996);
        n_vec++; if ({b0.bcd, b0.done, b0.running} !== {12'h999, 2'b01}) begin n_err++;
            $display("FAIL done_pre got %h/%b want 999/01", b0.bcd, {b0.done, b0.running}); end
        wait_n(3);
        n_vec++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL done_early got %b want 0", b0.done); end
        wait_n(1);
        n_vec++; if ({b0.bcd, b0.done, b0.running} !== {12'h999, 2'b10}) begin n_err++;
            $display("FAIL done_enter got %h/%b want 999/10", b0.bcd, {b0.done, b0.running}); end
        wait_n(8);
        press(0, 0);
        press(0, 1);
        n_vec++; if ({b0.bcd, b0.done, b0.running, b0.lap_active} !== {12'h999, 3'b100}) begin n_err++;
            $display("FAIL done_ignore got %h/%b want 999/100", b0.bcd, {b0.done, b0.running, b0.lap_active}); end
        press(0, 2);
        n_vec++; if ({b0.bcd, b0.done} !== {12'h000, 1'b0}) begin n_err++;
            $display("FAIL done_clear got %h/%b want 000/0", b0.bcd, b0.done); end
    endtask

    task automatic test_wrap();
        do_reset();
        press(1, 0);
        wait_n(3999);
        n_vec++; if ({b1.bcd, b1.ovf} !== {12'h999, 1'b0}) begin n_err++;
            $display("FAIL wrap_pre got %h/%b want 999/0", b1.bcd, b1.ovf); end
        wait_n(1);
        n_vec++; if ({b1.bcd, b1.ovf, b1.running, b1.done} !== {12'h000, 3'b110}) begin n_err++;
            $display("FAIL wrap_edge got %h/%b want 000/110", b1.bcd, {b1.ovf, b1.running, b1.done}); end
        wait_n(1);
        n_vec++; if (b1.ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf_len got %b want 0", b1.ovf); end
        wait_n(3);
        n_vec++; if (b1.bcd !== 12'h001) begin n_err++; $display("FAIL wrap_next got %h want 001", b1.bcd); end
    endtask

    task automatic test_edges();
        // start_stop and clear together in PAUSE: clear wins
        do_reset();
        press(0, 0);
        wait_n(10);
        press(0, 0);
        b0.start_stop = 1'b1; b0.clear = 1'b1;
        @(negedge clk);
        b0.start_stop = 1'b0; b0.clear = 1'b0;
        wait_n(8);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h000, 1'b0}) begin n_err++;
            $display("FAIL ss_clr_pause got %h/%b want 000/0", b0.bcd, b0.running); end

        // start_stop held across reset gives no event
        b0.start_stop = 1'b1;
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        wait_n(10);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h000, 1'b0}) begin n_err++;
            $display("FAIL held_reset got %h/%b want 000/0", b0.bcd, b0.running); end
        b0.start_stop = 1'b0;
        wait_n(1);
        press(0, 0);
        n_vec++; if (b0.running !== 1'b1) begin n_err++; $display("FAIL held_repress got %b want 1", b0.running); end

        // reset mid-run
        do_reset();
        press(0, 0);
        wait_n(587);
        n_vec++; if (b0.bcd !== 12'h146) begin n_err++; $display("FAIL midrun_pre got %h want 146", b0.bcd); end
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        n_vec++; if ({b0.bcd, b0.running, b0.lap_active, b0.done, b0.ovf} !== 16'd0) begin n_err++;
            $display("FAIL midrun_reset got %h want 0", {b0.bcd, b0.running, b0.lap_active, b0.done, b0.ovf}); end

        // start_stop coincident with tick at 009
        wait_n(1);
        press(0, 0);
        wait_n(39);
        n_vec++; if (b0.bcd !== 12'h009) begin n_err++; $display("FAIL coinc_pre got %h want 009", b0.bcd); end
        press(0, 0);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h010, 1'b0}) begin n_err++;
            $display("FAIL coinc_edge got %h/%b want 010/0", b0.bcd, b0.running); end
        wait_n(8);
        n_vec++; if ({b0.bcd, b0.running} !== {12'h010, 1'b0}) begin n_err++;
            $display("FAIL coinc_hold got %h/%b want 010/0", b0.bcd, b0.running); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sclr  = 1'b0;
        b0.start_stop = 1'b0; b0.lap = 1'b0; b0.clear = 1'b0;
        b1.start_stop = 1'b0; b1.lap = 1'b0; b1.clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_pause_resume();
        test_lap();
        test_done();
        test_wrap();
        test_edges();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
